count_wrap_monitor: RTL and testbench
=====================================

COUNT_WRAP_MONITOR -- requirements
Module: count_wrap_monitor

Interface
REQ-001 Parameter N, default 3: width of monitored count value; legal range N >= 2.
REQ-002 Parameter WRAP_W, default 8: width of wrap_count.
REQ-003 Parameter STALL_LIM, default 4: consecutive unchanged samples that declare a stall; legal range 1..255.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 clr  input  1  synchronous clear of monitor state, active-high.
REQ-007 cnt_in  input  N  count value sampled every cycle from the upstream counter.
REQ-008 wrap_pulse  output  1  one-cycle pulse marking a detected wrap-around.
REQ-009 dir  output  1  last observed step direction: 1 = up, 0 = down.
REQ-010 wrap_count  output  WRAP_W  number of wraps seen, saturating.
REQ-011 stalled  output  1  high while in STALL state.
REQ-012 step_err  output  1  sticky flag: an illegal step was observed.
REQ-013 state  output  2  FSM state: INIT=0, UP=1, DOWN=2, STALL=3.

Function
REQ-014 Block shall hold prev (N bits): cnt_in registered every cycle.
REQ-015 delta = (cnt_in - prev) mod 2^N; delta==1 -> up step; delta==2^N-1 -> down step; delta==0 -> hold; any other -> illegal step.
REQ-016 INIT: first cycle after reset or clr; prev captured, no step classified, all flags held; next state UP unconditionally.
REQ-017 UP/DOWN: up step -> UP, dir<=1; down step -> DOWN, dir<=0; hold -> stay, stall counter +1.
REQ-018 Stall counter shall clear on any step or illegal step; on reaching STALL_LIM -> STALL, stalled<=1.
REQ-019 STALL: hold -> stay; up step -> UP; down step -> DOWN; stalled clears on exit.
REQ-020 Up wrap = up step with prev==2^N-1 and cnt_in==0; down wrap = down step with prev==0 and cnt_in==2^N-1.
REQ-021 wrap_pulse shall be high exactly one cycle, registered: asserted on the clock edge following the sampled wrap (latency 1 from cnt_in change).
REQ-022 wrap_count shall increment on each wrap of either direction, saturating at 2^WRAP_W-1 (no roll-over).
REQ-023 Illegal step shall set step_err (sticky until clr/reset), update prev, not change dir, state, or wrap_count, and clear stall counter.
REQ-024 Back-to-back wraps (e.g. direction reversal 7->0->7 for N=3) shall each produce a pulse and an increment.
REQ-025 clr shall take priority over all same-cycle events: state<=INIT, wrap_count<=0, step_err<=0, stalled<=0, wrap_pulse<=0, stall counter<=0, dir<=1; prev still captures cnt_in.
REQ-026 Wrap detected in STALL exit cycle shall pulse and count as normal.

Reset
REQ-027 reset low shall immediately force: state=INIT, prev=0, dir=1, wrap_pulse=0, wrap_count=0, stalled=0, step_err=0, stall counter=0.
REQ-028 Reset asserted mid-operation shall abort any pending pulse; no pulse after release until a new wrap is sampled post-INIT.
REQ-029 First sample after reset release is captured in INIT and never classified as a step.

Verification (N=3, STALL_LIM=4 unless stated)
REQ-030 Up sweep 0,1,...,7,0 -> single wrap_pulse one cycle after 0 sampled; wrap_count=1; dir=1; state=UP.
REQ-031 Down sweep 7,6,...,0,7 -> single wrap_pulse; wrap_count=1; dir=0; state=DOWN.
REQ-032 Hold cnt_in=5 for 4 cycles after a step -> stalled=1, state=3; then 6 -> stalled=0, state=UP.
REQ-033 Jump 2->5 -> step_err=1 and stays 1 through later legal steps; clr -> step_err=0, state=INIT.
REQ-034 WRAP_W=2, 5 up wraps -> wrap_count saturates at 3; wrap_pulse still fires 5 times.
REQ-035 reset low mid-sweep at cnt_in=7 before 0 arrives -> all outputs zero (dir=1) asynchronously; no wrap_pulse on subsequent 0.

Source files
------------

// File: rtl/count_wrap_monitor.sv
`default_nettype none
// ============================================================================
// Module   : count_wrap_monitor
// Purpose  : Tracks an upstream counter's step direction, wraps, stalls and illegal jumps.
// Revision : 1.0  initial release
// ============================================================================
module count_wrap_monitor #(
  parameter int N         = 3,
  parameter int WRAP_W    = 8,
  parameter int STALL_LIM = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic [N-1:0]      cnt_in,
  output logic              wrap_pulse,
  output logic              dir,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              stalled,
  output logic              step_err,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_UP    = 2'd1,
    S_DOWN  = 2'd2,
    S_STALL = 2'd3
  } state_t;

  localparam logic [N-1:0] C_ONE     = N'(1);
  localparam logic [N-1:0] C_MAX     = {N{1'b1}};
  localparam logic [7:0]   C_LIM     = 8'(STALL_LIM);

  state_t            r_state, w_state_nxt;
  logic [N-1:0]      r_prev;
  logic              r_dir, w_dir_nxt;
  logic              r_pulse, w_pulse_nxt;
  logic [WRAP_W-1:0] r_wcnt, w_wcnt_nxt;
  logic              r_stalled;
  logic              r_err, w_err_nxt;
  logic [7:0]        r_scnt, w_scnt_nxt;

  logic [N-1:0]      w_delta;
  logic              w_up, w_down, w_hold, w_wrap;

  // Modular difference classifies the step independent of absolute value.
  assign w_delta = cnt_in - r_prev;
  assign w_up    = (w_delta == C_ONE);
  assign w_down  = (w_delta == C_MAX);
  assign w_hold  = (w_delta == '0);
  assign w_wrap  = (w_up   && (r_prev == C_MAX) && (cnt_in == '0)) ||
                   (w_down && (r_prev == '0)    && (cnt_in == C_MAX));

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_pulse_nxt = 1'b0;
    w_wcnt_nxt  = r_wcnt;
    w_err_nxt   = r_err;
    w_scnt_nxt  = r_scnt;
    if (clr) begin
      w_state_nxt = S_INIT;
      w_dir_nxt   = 1'b1;
      w_wcnt_nxt  = '0;
      w_err_nxt   = 1'b0;
      w_scnt_nxt  = '0;
    end else if (r_state == S_INIT) begin
      w_state_nxt = S_UP;
    end else if (w_up || w_down) begin
      w_state_nxt = w_up ? S_UP : S_DOWN;
      w_dir_nxt   = w_up;
      w_scnt_nxt  = '0;
      if (w_wrap) begin
        w_pulse_nxt = 1'b1;
        if (r_wcnt != {WRAP_W{1'b1}}) w_wcnt_nxt = r_wcnt + 1'b1;
      end
    end else if (w_hold) begin
      if (r_state != S_STALL) begin
        if (r_scnt + 8'd1 >= C_LIM) begin
          w_state_nxt = S_STALL;
          w_scnt_nxt  = '0;
        end else begin
          w_scnt_nxt = r_scnt + 8'd1;
        end
      end
    end else begin
      // Illegal jump: flag it but leave direction, state and wrap count alone.
      w_err_nxt  = 1'b1;
      w_scnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_INIT;
      r_prev    <= '0;
      r_dir     <= 1'b1;
      r_pulse   <= 1'b0;
      r_wcnt    <= '0;
      r_stalled <= 1'b0;
      r_err     <= 1'b0;
      r_scnt    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_prev    <= cnt_in;
      r_dir     <= w_dir_nxt;
      r_pulse   <= w_pulse_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_stalled <= (w_state_nxt == S_STALL);
      r_err     <= w_err_nxt;
      r_scnt    <= w_scnt_nxt;
    end
  end

  assign wrap_pulse = r_pulse;
  assign dir        = r_dir;
  assign wrap_count = r_wcnt;
  assign stalled    = r_stalled;
  assign step_err   = r_err;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_count_wrap_monitor.sv
`default_nettype none
// Directed bench for count_wrap_monitor (N=3, STALL_LIM=4, WRAP_W=2 to reach saturation quickly).
module tb_count_wrap_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] cnt_in = 3'd0;
  logic       wrap_pulse, dir, stalled, step_err;
  logic [1:0] wrap_count;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  count_wrap_monitor #(.N(3), .WRAP_W(2), .STALL_LIM(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .cnt_in     (cnt_in),
    .wrap_pulse (wrap_pulse),
    .dir        (dir),
    .wrap_count (wrap_count),
    .stalled    (stalled),
    .step_err   (step_err),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present a sample, let one rising edge take it, then settle past the edge.
  task automatic tick(input logic [2:0] v);
    cnt_in = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_dir", dir, 1);
    chk("rst_pulse", wrap_pulse, 0);
    chk("rst_wcnt", wrap_count, 0);
    chk("rst_stalled", stalled, 0);
    chk("rst_err", step_err, 0);
    reset = 1'b1;

    // Up sweep with one wrap
    tick(3'd0);
    chk("init_to_up", state, 1);
    for (int v = 1; v <= 7; v++) begin
      tick(3'(v));
      chk("up_nopulse", wrap_pulse, 0);
    end
    tick(3'd0);
    chk("upwrap_pulse", wrap_pulse, 1);
    chk("upwrap_wcnt", wrap_count, 1);
    chk("upwrap_dir", dir, 1);
    chk("upwrap_state", state, 1);
    tick(3'd1);
    chk("upwrap_single", wrap_pulse, 0);

    // Down sweep after clear, then back-to-back wraps into saturation
    clr = 1'b1;
    tick(3'd7);
    chk("clr_state", state, 0);
    chk("clr_wcnt", wrap_count, 0);
    clr = 1'b0;
    tick(3'd7);
    chk("init_nostep_dir", dir, 1);
    for (int v = 6; v >= 0; v--) begin
      tick(3'(v));
      chk("down_nopulse", wrap_pulse, 0);
    end
    chk("down_dir", dir, 0);
    tick(3'd7);
    chk("dnwrap_pulse", wrap_pulse, 1);
    chk("dnwrap_wcnt", wrap_count, 1);
    chk("dnwrap_dir", dir, 0);
    chk("dnwrap_state", state, 2);
    tick(3'd0);
    chk("b2b_pulse2", wrap_pulse, 1);
    chk("b2b_wcnt2", wrap_count, 2);
    chk("b2b_dir2", dir, 1);
    tick(3'd7);
    chk("b2b_pulse3", wrap_pulse, 1);
    chk("b2b_wcnt3", wrap_count, 3);
    tick(3'd0);
    chk("sat_pulse4", wrap_pulse, 1);
    chk("sat_wcnt4", wrap_count, 3);
    tick(3'd7);
    chk("sat_pulse5", wrap_pulse, 1);
    chk("sat_wcnt5", wrap_count, 3);

    // Stall detection at exactly four holds
    clr = 1'b1;
    tick(3'd4);
    clr = 1'b0;
    tick(3'd4);
    tick(3'd5);
    for (int i = 0; i < 3; i++) tick(3'd5);
    chk("stall_below_lim", stalled, 0);
    chk("stall_below_state", state, 1);
    tick(3'd5);
    chk("stall_set", stalled, 1);
    chk("stall_state", state, 3);
    tick(3'd5);
    chk("stall_stay", state, 3);
    tick(3'd6);
    chk("stall_exit", stalled, 0);
    chk("stall_exit_state", state, 1);

    // Illegal jump is sticky and leaves dir/state alone
    clr = 1'b1;
    tick(3'd2);
    clr = 1'b0;
    tick(3'd2);
    tick(3'd5);
    chk("jump_err", step_err, 1);
    chk("jump_state", state, 1);
    tick(3'd4);
    chk("jump_sticky", step_err, 1);
    chk("jump_down_dir", dir, 0);
    tick(3'd1);
    chk("jump2_dir", dir, 0);
    chk("jump2_state", state, 2);
    clr = 1'b1;
    tick(3'd1);
    chk("jump_clr_err", step_err, 0);
    chk("jump_clr_state", state, 0);
    clr = 1'b0;

    // Wrap on the cycle that leaves STALL
    tick(3'd7);
    for (int i = 0; i < 4; i++) tick(3'd7);
    chk("stallwrap_pre", state, 3);
    tick(3'd0);
    chk("stallwrap_pulse", wrap_pulse, 1);
    chk("stallwrap_wcnt", wrap_count, 1);
    chk("stallwrap_state", state, 1);

    // Clear wins over a same-cycle wrap
    tick(3'd7);
    clr = 1'b1;
    tick(3'd0);
    chk("clrwrap_pulse", wrap_pulse, 0);
    chk("clrwrap_wcnt", wrap_count, 0);
    clr = 1'b0;

    // Asynchronous reset mid-sweep at 7
    tick(3'd6);
    tick(3'd7);
    chk("pre_rst_state", state, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_dir", dir, 1);
    chk("arst_pulse", wrap_pulse, 0);
    chk("arst_err", step_err, 0);
    cnt_in = 3'd0;
    @(posedge clk);
    #1 reset = 1'b1;
    tick(3'd0);
    chk("post_rst_pulse_init", wrap_pulse, 0);
    tick(3'd0);
    chk("post_rst_pulse", wrap_pulse, 0);
    chk("post_rst_wcnt", wrap_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
